// File: rtl/signal_capture.sv
// Debug sink: records a 4-phase parallel sample stream into a 2^NB_ADDR buffer,
// then replays it one sample per valid/ready transfer.
module signal_capture #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_sample_0,
  input  logic [NB_DATA-1:0] i_sample_1,
  input  logic [NB_DATA-1:0] i_sample_2,
  input  logic [NB_DATA-1:0] i_sample_3,
  input  logic               i_rd_ready,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam logic [NB_ADDR-1:0] WR_LAST = NB_ADDR'(DEPTH - 4);
  localparam logic [NB_ADDR-1:0] RD_LAST = NB_ADDR'(DEPTH - 1);
  localparam logic [NB_ADDR-1:0] WR_STEP = NB_ADDR'(4);
  localparam logic [NB_ADDR-1:0] RD_STEP = NB_ADDR'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic               done_q, done_d;
  logic               wr_en;

  logic [NB_DATA-1:0] mem_q [DEPTH];

  // Handshake: o_rd_valid is high for the whole READOUT state; a transfer
  // happens on an edge where o_rd_valid and i_rd_ready are both high, and
  // o_rd_data holds until that transfer.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      S_CAPTURE: begin
        if (i_valid) begin
          wr_en    = ~i_reset;
          wr_ptr_d = wr_ptr_q + WR_STEP;
          if (wr_ptr_q == WR_LAST) state_d = S_READOUT;
        end
      end
      S_READOUT: begin
        if (i_rd_ready) begin
          rd_ptr_d = rd_ptr_q + RD_STEP;
          if (rd_ptr_q == RD_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  // wr_ptr is always 4-aligned, so the phase index fills the low two bits.
  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      mem_q[{wr_ptr_q[NB_ADDR-1:2], 2'd0}] <= i_sample_0;
      mem_q[{wr_ptr_q[NB_ADDR-1:2], 2'd1}] <= i_sample_1;
      mem_q[{wr_ptr_q[NB_ADDR-1:2], 2'd2}] <= i_sample_2;
      mem_q[{wr_ptr_q[NB_ADDR-1:2], 2'd3}] <= i_sample_3;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_rd_valid = (state_q == S_READOUT);
  assign o_rd_data  = (state_q == S_READOUT) ? mem_q[rd_ptr_q] : '0;
  assign o_done     = done_q;

endmodule

// File: tb/tb_signal_capture.sv
// Self-checking bench for signal_capture at NB_ADDR=4 (16-sample buffer),
// compared against an arrival-order sample model.
module tb_signal_capture;

  localparam int NB_DATA = 8;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               i_start;
  logic               i_valid;
  logic [NB_DATA-1:0] i_sample_0, i_sample_1, i_sample_2, i_sample_3;
  logic               i_rd_ready;
  logic [NB_DATA-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               o_busy;
  logic               o_done;

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0 idle, 1 capturing, 2 replaying.
  int               m_mode = 0;
  int               m_wcnt = 0;
  int               m_ridx = 0;
  logic             m_done = 1'b0;
  logic [NB_DATA-1:0] m_buf [DEPTH];

  logic [NB_DATA-1:0] exp_q [$];
  logic [NB_DATA-1:0] got_q [$];

  signal_capture #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .i_sample_0(i_sample_0), .i_sample_1(i_sample_1),
    .i_sample_2(i_sample_2), .i_sample_3(i_sample_3),
    .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  // Drives one clock cycle from a negedge, advances the model, returns at the next negedge.
  task automatic cycle(input logic st, input logic va,
                       input logic [NB_DATA-1:0] s0, s1, s2, s3, input logic rdy);
    i_start = st; i_valid = va; i_rd_ready = rdy;
    i_sample_0 = s0; i_sample_1 = s1; i_sample_2 = s2; i_sample_3 = s3;
    @(posedge i_clock);
    m_done = 1'b0;
    if (i_reset) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_wcnt = 0; end
    end else if (m_mode == 1) begin
      if (va) begin
        m_buf[m_wcnt] = s0; m_buf[m_wcnt+1] = s1; m_buf[m_wcnt+2] = s2; m_buf[m_wcnt+3] = s3;
        m_wcnt += 4;
        if (m_wcnt == DEPTH) begin m_mode = 2; m_ridx = 0; end
      end
    end else if (rdy) begin
      m_ridx++;
      if (m_ridx == DEPTH) begin m_mode = 0; m_done = 1'b1; end
    end
    @(negedge i_clock);
  endtask

  // Starts (optionally) and feeds 4 bundles; mode 0 contiguous, 1 fixed gap pattern, 2 random gaps/data.
  task automatic capture(input int base, input int mode, input bit do_start,
                         input bit start_noise, input bit junk_on_start);
    logic [NB_DATA-1:0] d [4];
    logic [6:0] gap_pat;
    logic va, st;
    logic [NB_DATA-1:0] e_data;
    int b;
    gap_pat = 7'b1011001;
    exp_q.delete();
    got_q.delete();
    if (do_start) cycle(1'b1, junk_on_start, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
    b = 0;
    for (int c = 0; c < 200 && b < 4; c++) begin
      case (mode)
        0:       va = 1'b1;
        1:       va = gap_pat[c % 7];
        default: va = 1'($urandom_range(0, 1));
      endcase
      for (int k = 0; k < 4; k++)
        d[k] = (mode == 2) ? NB_DATA'($urandom_range(0, 255)) : NB_DATA'(base + 4*b + k);
      st = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (va) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(d[k]);
        b++;
      end
      cycle(st, va, d[0], d[1], d[2], d[3], 1'b0);
      e_data = (m_mode == 2) ? m_buf[m_ridx] : '0;
      checks++;
      if ({o_busy, o_rd_valid, o_done, o_rd_data} !== {1'b1, (b == 4), 1'b0, e_data}) begin
        errors++;
        $display("FAIL capture_cycle c=%0d bundles=%0d: busy=%b valid=%b done=%b data=%0d, want busy=1 valid=%b done=0 data=%0d",
                 c, b, o_busy, o_rd_valid, o_done, o_rd_data, (b == 4), e_data);
      end
    end
  endtask

  // Replays until o_done; ready_mode 0 always, 1 pattern 1,0,0, 2 random.
  task automatic drain(input int ready_mode, input bit start_noise,
                       output int hs, output int hold_err, output bit done_seen);
    logic [NB_DATA-1:0] pre_d, e_data;
    logic pre_v, rdy, st;
    hs = 0; hold_err = 0; done_seen = 1'b0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      st = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pre_d = o_rd_data; pre_v = o_rd_valid;
      if (o_rd_valid && rdy) begin got_q.push_back(o_rd_data); hs++; end
      cycle(st, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, rdy);
      if (pre_v && !rdy && !(o_rd_valid === 1'b1 && o_rd_data === pre_d)) hold_err++;
      e_data = (m_mode == 2) ? m_buf[m_ridx] : '0;
      checks++;
      if ({o_busy, o_rd_valid, o_done, o_rd_data} !== {(m_mode != 0), (m_mode == 2), m_done, e_data}) begin
        errors++;
        $display("FAIL drain_cycle c=%0d: busy=%b valid=%b done=%b data=%0d, want busy=%b valid=%b done=%b data=%0d",
                 c, o_busy, o_rd_valid, o_done, o_rd_data, (m_mode != 0), (m_mode == 2), m_done, e_data);
      end
      if (o_done === 1'b1) done_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    cycle(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    i_reset = 1'b0;
    checks++;
    if ({o_busy, o_rd_valid, o_done, o_rd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b done=%b data=%0d, want all 0",
               o_busy, o_rd_valid, o_done, o_rd_data);
    end
  endtask

  task automatic test_basic(input string name, input int gap_mode, input int ready_mode);
    int hs, hold_err;
    bit done_seen;
    capture(0, gap_mode, 1'b1, 1'b0, 1'b0);
    drain(ready_mode, 1'b0, hs, hold_err, done_seen);
    checks++;
    if (!done_seen || hs != DEPTH || hold_err != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_summary: done=%0d handshakes=%0d hold_err=%0d busy=%b, want 1/16/0/0",
               name, done_seen, hs, hold_err, o_busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== NB_DATA'(i)) begin
        errors++;
        $display("FAIL %s_seq[%0d]: got %0d, want %0d", name, i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, i);
      end
    end
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b valid=%b, want 0/0/0", name, o_done, o_busy, o_rd_valid);
    end
  endtask

  task automatic test_start_ignored();
    int hs, hold_err;
    bit done_seen;
    capture(50, 0, 1'b1, 1'b1, 1'b0);
    drain(2, 1'b1, hs, hold_err, done_seen);
    checks++;
    if (!done_seen || hs != DEPTH || hold_err != 0 || got_q != exp_q) begin
      errors++;
      $display("FAIL start_noise_run: done=%0d handshakes=%0d hold_err=%0d got=%p want=%p",
               done_seen, hs, hold_err, got_q, exp_q);
    end
    // Start asserted in the o_done cycle begins a new capture.
    cycle(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy=%b valid=%b, want 1/0", o_busy, o_rd_valid);
    end
    capture(100, 0, 1'b0, 1'b0, 1'b0);
    drain(0, 1'b0, hs, hold_err, done_seen);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== NB_DATA'(100 + i)) begin
        errors++;
        $display("FAIL restart_seq[%0d]: got %0d, want %0d", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, 100 + i);
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    int hs, hold_err;
    bit done_seen;
    cycle(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 8'd70, 8'd71, 8'd72, 8'd73, 1'b0);
    cycle(1'b0, 1'b1, 8'd74, 8'd75, 8'd76, 8'd77, 1'b0);
    i_reset = 1'b1;
    cycle(1'b0, 1'b1, 8'd78, 8'd79, 8'd80, 8'd81, 1'b1);
    i_reset = 1'b0;
    checks++;
    if ({o_busy, o_rd_valid, o_done, o_rd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b done=%b data=%0d, want all 0",
               o_busy, o_rd_valid, o_done, o_rd_data);
    end
    cycle(1'b0, 1'b1, 8'd82, 8'd83, 8'd84, 8'd85, 1'b1);
    checks++;
    if (o_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b valid=%b, want 0/0", o_busy, o_rd_valid);
    end
    capture(200, 1, 1'b1, 1'b0, 1'b0);
    drain(1, 1'b0, hs, hold_err, done_seen);
    checks++;
    if (!done_seen || hs != DEPTH || hold_err != 0 || got_q != exp_q) begin
      errors++;
      $display("FAIL reset_mid_replay: done=%0d handshakes=%0d hold_err=%0d got=%p want=%p",
               done_seen, hs, hold_err, got_q, exp_q);
    end
  endtask

  task automatic test_idle_valid();
    int hs, hold_err, nines;
    bit done_seen;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'd9, 8'd9, 8'd9, 8'd9, 1'b1);
    capture(20, 0, 1'b1, 1'b0, 1'b1);
    drain(0, 1'b0, hs, hold_err, done_seen);
    nines = 0;
    foreach (got_q[i]) if (got_q[i] === 8'd9) nines++;
    checks++;
    if (nines != 0 || got_q != exp_q || hs != DEPTH) begin
      errors++;
      $display("FAIL idle_valid: nines=%0d handshakes=%0d got=%p want=%p", nines, hs, got_q, exp_q);
    end
  endtask

  task automatic test_random();
    int hs, hold_err;
    bit done_seen;
    for (int r = 0; r < 4; r++) begin
      capture(0, 2, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      drain(2, 1'b1, hs, hold_err, done_seen);
      checks++;
      if (!done_seen || hs != DEPTH || hold_err != 0 || got_q != exp_q) begin
        errors++;
        $display("FAIL random_run%0d: done=%0d handshakes=%0d hold_err=%0d got=%p want=%p",
                 r, done_seen, hs, hold_err, got_q, exp_q);
      end
      for (int i = 0; i < $urandom_range(0, 3); i++)
        cycle(1'b0, 1'($urandom_range(0, 1)), 8'd9, 8'd9, 8'd9, 8'd9, 1'b1);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_rd_ready = 1'b0;
    i_sample_0 = '0; i_sample_1 = '0; i_sample_2 = '0; i_sample_3 = '0;
    @(negedge i_clock);
    test_reset();
    test_basic("basic", 0, 0);
    test_basic("gaps", 1, 0);
    test_basic("backpressure", 0, 1);
    test_start_ignored();
    test_reset_mid_capture();
    test_idle_valid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
